// File: rtl/pc_fetch_sequencer.sv
// Fetch PC sequencer: owns the PC, issues valid/ready fetches, applies branch/jump redirects with a one-entry pending buffer.
// Latency: redirect-to-PC 1 cycle; a request held under !ImemReady keeps PC stable and parks late redirects until accept.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchValid,
    input  logic [31:0] BranchTarget,
    input  logic        JumpValid,
    input  logic [25:0] JumpIndex,
    input  logic        ImemReady,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        FetchValid,
    output logic        Flush,
    output logic        Misaligned
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        waiting_q, waiting_d;
    logic        pend_vld_q, pend_vld_d;
    logic        pend_is_branch_q, pend_is_branch_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        misaligned_q, misaligned_d;

    logic        run;
    logic        redir;
    logic [31:0] jump_tgt;
    logic [31:0] redir_tgt;
    logic        fv_raw;
    logic        accept_raw;
    logic        apply;
    logic        blocked;
    logic        drain;
    logic        load;
    logic [31:0] load_tgt;
    logic        bad_tgt;
    logic        fetch_vld;
    logic        accept;

    always_comb begin
        run        = (state_q == ST_RUN);
        redir      = BranchValid | JumpValid;
        jump_tgt   = {pc_q[31:28], JumpIndex, 2'b00};
        // Branch belongs to the older instruction, so a same-cycle jump is on the squashed path.
        redir_tgt  = BranchValid ? BranchTarget : jump_tgt;
        fv_raw     = run & (~Stall | waiting_q);
        accept_raw = fv_raw & ImemReady;
        apply      = run & redir & (~waiting_q | ImemReady);
        blocked    = run & redir & waiting_q & ~ImemReady;
        drain      = pend_vld_q & accept_raw & ~redir;
        load       = apply | drain;
        load_tgt   = apply ? redir_tgt : pend_tgt_q;
        bad_tgt    = load & (load_tgt[1:0] != 2'b00);
        fetch_vld  = fv_raw & ~bad_tgt;
        accept     = fetch_vld & ImemReady;

        state_d          = state_q;
        pc_d             = pc_q;
        waiting_d        = fetch_vld & ~ImemReady;
        pend_vld_d       = pend_vld_q;
        pend_is_branch_d = pend_is_branch_q;
        pend_tgt_d       = pend_tgt_q;
        misaligned_d     = misaligned_q;

        if (state_q == ST_INIT) begin
            state_d = ST_RUN;
        end

        if (bad_tgt) begin
            state_d      = ST_HALT;
            misaligned_d = 1'b1;
            pend_vld_d   = 1'b0;
        end else if (load) begin
            pc_d       = load_tgt;
            pend_vld_d = 1'b0;
        end else if (accept & ~Stall) begin
            pc_d = pc_q + 32'd4;
        end

        // A parked branch must survive a later jump; a branch replaces anything.
        if (blocked) begin
            if (BranchValid) begin
                pend_vld_d       = 1'b1;
                pend_is_branch_d = 1'b1;
                pend_tgt_d       = BranchTarget;
            end else if (~pend_vld_q | ~pend_is_branch_q) begin
                pend_vld_d       = 1'b1;
                pend_is_branch_d = 1'b0;
                pend_tgt_d       = jump_tgt;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q          <= ST_INIT;
            pc_q             <= RESET_PC;
            waiting_q        <= 1'b0;
            pend_vld_q       <= 1'b0;
            pend_is_branch_q <= 1'b0;
            pend_tgt_q       <= 32'h0;
            misaligned_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            waiting_q        <= waiting_d;
            pend_vld_q       <= pend_vld_d;
            pend_is_branch_q <= pend_is_branch_d;
            pend_tgt_q       <= pend_tgt_d;
            misaligned_q     <= misaligned_d;
        end
    end

    assign PC         = pc_q;
    assign PCPlus4    = pc_q + 32'd4;
    assign FetchValid = fetch_vld;
    assign Flush      = load;
    assign Misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: each stimulus cycle pushes its hand-computed expected outputs, a negedge monitor pops and compares.
module tb_pc_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        BranchValid;
    logic [31:0] BranchTarget;
    logic        JumpValid;
    logic [25:0] JumpIndex;
    logic        ImemReady;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        FetchValid;
    logic        Flush;
    logic        Misaligned;

    typedef struct packed {
        logic [31:0] pc;
        logic        fv;
        logic        fl;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;

    pc_fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .BranchValid  (BranchValid),
        .BranchTarget (BranchTarget),
        .JumpValid    (JumpValid),
        .JumpIndex    (JumpIndex),
        .ImemReady    (ImemReady),
        .PC           (PC),
        .PCPlus4      (PCPlus4),
        .FetchValid   (FetchValid),
        .Flush        (Flush),
        .Misaligned   (Misaligned)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL cycle %0d %s: got %h expected %h", cycle_no, name, act, req);
        end
    endtask

    // Monitor: pops one expectation per presented cycle.
    always @(negedge Clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("PC",         PC,                  e.pc);
            chk("PCPlus4",    PCPlus4,             e.pc + 32'd4);
            chk("FetchValid", {31'd0, FetchValid}, {31'd0, e.fv});
            chk("Flush",      {31'd0, Flush},      {31'd0, e.fl});
            chk("Misaligned", {31'd0, Misaligned}, {31'd0, e.mis});
        end
    end

    task automatic cyc(input logic rst, input logic stl, input logic bv, input logic [31:0] bt,
                       input logic jv, input logic [25:0] ji, input logic rdy,
                       input logic [31:0] e_pc, input logic e_fv, input logic e_fl, input logic e_mis);
        exp_t e;
        @(posedge Clk);
        #1;
        cycle_no++;
        Reset        = rst;
        Stall        = stl;
        BranchValid  = bv;
        BranchTarget = bt;
        JumpValid    = jv;
        JumpIndex    = ji;
        ImemReady    = rdy;
        e.pc  = e_pc;
        e.fv  = e_fv;
        e.fl  = e_fl;
        e.mis = e_mis;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; Stall = 1'b0; BranchValid = 1'b0; BranchTarget = 32'h0;
        JumpValid = 1'b0; JumpIndex = 26'h0; ImemReady = 1'b1;

        //  rst stl bv bt            jv ji       rdy  pc            fv fl mis
        cyc(1, 0, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0000, 0, 0, 0); // reset state
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0000, 0, 0, 0); // INIT
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0000, 1, 0, 0); // first fetch
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0004, 1, 0, 0);
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0008, 1, 0, 0);
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   1, 32'h0000_000C, 1, 0, 0);
        cyc(0, 0, 1, 32'h40,       0, 26'h0,   1, 32'h0000_0010, 1, 1, 0); // branch
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0040, 1, 0, 0);
        cyc(0, 0, 1, 32'h1000_0008,0, 26'h0,   1, 32'h0000_0044, 1, 1, 0);
        cyc(0, 0, 0, 32'h0,        1, 26'h100, 1, 32'h1000_0008, 1, 1, 0); // jump
        cyc(0, 0, 1, 32'h100,      0, 26'h0,   1, 32'h1000_0400, 1, 1, 0);
        // blocked jump then overwriting branch
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   0, 32'h0000_0100, 1, 0, 0);
        cyc(0, 0, 0, 32'h0,        1, 26'h80,  0, 32'h0000_0100, 1, 0, 0);
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   0, 32'h0000_0100, 1, 0, 0);
        cyc(0, 0, 1, 32'h80,       0, 26'h0,   0, 32'h0000_0100, 1, 0, 0);
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   0, 32'h0000_0100, 1, 0, 0);
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   0, 32'h0000_0100, 1, 0, 0);
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0100, 1, 1, 0); // drain
        // stall raised while waiting
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   0, 32'h0000_0080, 1, 0, 0);
        cyc(0, 1, 0, 32'h0,        0, 26'h0,   0, 32'h0000_0080, 1, 0, 0);
        cyc(0, 1, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0080, 1, 0, 0);
        cyc(0, 1, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0080, 0, 0, 0);
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0080, 1, 0, 0);
        // pending branch is not replaced by a later jump
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   0, 32'h0000_0084, 1, 0, 0);
        cyc(0, 0, 1, 32'h300,      0, 26'h0,   0, 32'h0000_0084, 1, 0, 0);
        cyc(0, 0, 0, 32'h0,        1, 26'h10,  0, 32'h0000_0084, 1, 0, 0);
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0084, 1, 1, 0);
        // simultaneous branch and jump: branch wins
        cyc(0, 0, 1, 32'h500,      1, 26'h10,  1, 32'h0000_0300, 1, 1, 0);
        // redirect overrides stall
        cyc(0, 1, 1, 32'h600,      0, 26'h0,   1, 32'h0000_0500, 0, 1, 0);
        // wrap-around
        cyc(0, 0, 1, 32'hFFFF_FFFC,0, 26'h0,   1, 32'h0000_0600, 1, 1, 0);
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   1, 32'hFFFF_FFFC, 1, 0, 0);
        // misaligned branch target
        cyc(0, 0, 1, 32'h42,       0, 26'h0,   1, 32'h0000_0000, 0, 1, 0);
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0000, 0, 0, 1);
        cyc(0, 0, 1, 32'h80,       0, 26'h0,   1, 32'h0000_0000, 0, 0, 1);
        // mid-operation reset leaves HALT
        cyc(1, 0, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0000, 0, 0, 0);
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0000, 0, 0, 0);
        cyc(0, 0, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0000, 1, 0, 0);

        @(negedge Clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: got %0d leftover entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
